// File: rtl/nn_mem_pkg.sv
// Shared definitions for the NN memory loaders and readers.
// Holds the loader state encoding and the default memory geometry.
// Imported by the stream writer and the sequential reader.
package nn_mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/bram_stream_writer_if.sv
// Byte stream in plus BRAM write port out, as seen by the stream writer.
// master: the writer (consumes the stream, drives the BRAM port).
// slave: the surrounding environment (source and memory).
interface bram_stream_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;

  modport master (
    input  s_valid, s_data,
    output s_ready, bram_we, bram_addr, bram_din
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/bram_stream_writer.sv
// Fills DEPTH consecutive BRAM words from BASE_ADDR with bytes from a valid/ready stream.
// Latency: accepted beat appears on the BRAM write port one cycle later; one beat per cycle.
// Backpressure: s_ready high only in LOAD without abort; source gaps just stall the burst.
module bram_stream_writer
  import nn_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  bram_stream_writer_if.master  io,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(DEPTH - 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              s_ready_w;
  logic              accept;

  // Ready is the only combinational output: abort must block the beat in the same cycle.
  assign s_ready_w = (state_q == ST_LOAD) & ~abort;
  assign accept    = io.s_valid & s_ready_w;

  // Next-state, pointer/count and write-port register inputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start outranks abort here; abort is simply not looked at.
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = BASE;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          din_d   = io.s_data;
          ptr_d   = ptr_q + 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // The last write is on the port this cycle regardless of abort.
        state_d = abort ? ST_IDLE : ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset also drops any write staged from the previous beat.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign io.s_ready   = s_ready_w;
  assign io.bram_we   = we_q;
  assign io.bram_addr = addr_q;
  assign io.bram_din  = din_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign count        = count_q;

endmodule

// File: tb/tb_bram_stream_writer.sv
// Bench for bram_stream_writer: DEPTH=16 bursts at BASE_ADDR=0x20.
// Expected writes come from a list of accepted beats and a shadow memory.
// Observed writes are captured from the BRAM port into a second memory.
module tb_bram_stream_writer;

  localparam int N    = 16;
  localparam int BASE = 'h20;

  logic        clock = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [10:0] count;

  bram_stream_writer_if #(.DATA_W(8), .ADDR_W(10)) bus ();

  bram_stream_writer #(
    .DATA_W(8), .ADDR_W(10), .DEPTH(N), .BASE_ADDR(BASE)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .io    (bus.master),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  wr_t  exp_q[$];
  wr_t  obs_q[$];
  int   obs_cyc[$];
  logic [7:0] exp_mem [1024];
  logic [7:0] obs_mem [1024];

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Capture every write presented to the BRAM.
  always @(negedge clock) begin
    if (bus.bram_we === 1'b1) begin
      obs_q.push_back({bus.bram_addr, bus.bram_din});
      obs_cyc.push_back(cyc);
      obs_mem[bus.bram_addr] = bus.bram_din;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  // Offer n bytes d0, d0+1, ... while in LOAD; pulses start when beat start_at is offered.
  task automatic drive_burst(input int n, input bit gaps, input logic [7:0] d0, input int start_at);
    int acc = 0;
    int guard = 0;
    while (acc < n && guard < 400) begin
      bus.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = d0 + 8'(acc);
      start       = (acc == start_at);
      @(negedge clock);
      checks++;
      if (bus.s_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready beat %0d got %b exp 1", acc, bus.s_ready);
      end
      if (bus.s_valid) begin
        exp_q.push_back({10'(BASE + acc), bus.s_data});
        exp_mem[BASE + acc] = bus.s_data;
        acc++;
      end
      @(posedge clock);
      #1;
      guard++;
    end
    bus.s_valid = 1'b0;
    start       = 1'b0;
    checks++;
    if (acc != n) begin
      errors++;
      $display("FAIL burst_timeout accepted %0d exp %0d", acc, n);
    end
  endtask

  // Called in the cycle after the last accept: FLUSH, then DONE, then the write log.
  task automatic finish_burst(input string name, input bit contiguous);
    @(negedge clock);
    checks++;
    if (bus.s_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_flush ready %b busy %b done %b exp 0 1 0", name, bus.s_ready, busy, done);
    end
    checks++;
    if (bus.bram_we !== 1'b1 || bus.bram_addr !== 10'(BASE + N - 1)) begin
      errors++;
      $display("FAIL %s_last_write we %b addr %h exp 1 %h", name, bus.bram_we, bus.bram_addr, 10'(BASE + N - 1));
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 11'(N) || bus.bram_we !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done done %b busy %b count %0d we %b ready %b exp 1 0 %0d 0 0",
               name, done, busy, count, bus.bram_we, bus.s_ready, N);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_write_count got %0d exp %0d", name, obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_write[%0d] got %h:%h exp %h:%h", name, i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
        end
        if (contiguous && i > 0) begin
          checks++;
          if (obs_cyc[i] != obs_cyc[0] + i) begin
            errors++;
            $display("FAIL %s_gap[%0d] cycle %0d exp %0d", name, i, obs_cyc[i], obs_cyc[0] + i);
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_mem[BASE + i] !== exp_mem[BASE + i]) begin
        errors++;
        $display("FAIL %s_readback[%0d] got %h exp %h", name, i, obs_mem[BASE + i], exp_mem[BASE + i]);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 8'h5A;
    repeat (3) tick();
    @(negedge clock);
    checks++;
    if (bus.bram_we !== 1'b0 || bus.bram_addr !== 10'(BASE) || bus.bram_din !== 8'h00) begin
      errors++;
      $display("FAIL reset_port we %b addr %h din %h exp 0 %h 00", bus.bram_we, bus.bram_addr, bus.bram_din, 10'(BASE));
    end
    checks++;
    if (count !== 11'd0 || busy !== 1'b0 || done !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_status count %0d busy %b done %b ready %b exp 0 0 0 0", count, busy, done, bus.s_ready);
    end
    @(posedge clock);
    #1;
    rst = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (bus.s_ready !== 1'b0 || busy !== 1'b0 || bus.bram_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold ready %b busy %b we %b exp 0 0 0", bus.s_ready, busy, bus.bram_we);
    end
    @(posedge clock);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic test_full_burst();
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_burst(N, 1'b0, 8'h00, -1);
    finish_burst("full", 1'b1);
  endtask

  task automatic test_restart();
    clear_q();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || count !== 11'd0 || bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_entry done %b busy %b count %0d ready %b exp 0 1 0 1", done, busy, count, bus.s_ready);
    end
    @(posedge clock);
    #1;
    drive_burst(N, 1'b0, 8'hA0, -1);
    finish_burst("restart", 1'b1);
  endtask

  task automatic test_gaps();
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_burst(N, 1'b1, 8'($urandom), -1);
    finish_burst("gaps", 1'b0);
  endtask

  task automatic test_start_in_load();
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_burst(N, 1'b0, 8'($urandom), 3);
    finish_burst("start_in_load", 1'b1);
  endtask

  task automatic test_abort();
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_burst(5, 1'b0, 8'h40, -1);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    abort       = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_ready got %b exp 0", bus.s_ready);
    end
    checks++;
    if (bus.bram_we !== 1'b1 || bus.bram_addr !== 10'(BASE + 4)) begin
      errors++;
      $display("FAIL abort_pending_write we %b addr %h exp 1 %h", bus.bram_we, bus.bram_addr, 10'(BASE + 4));
    end
    @(posedge clock);
    #1;
    abort = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 11'd5 || bus.bram_we !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy %b done %b count %0d we %b ready %b exp 0 0 5 0 0",
               busy, done, count, bus.bram_we, bus.s_ready);
    end
    @(posedge clock);
    #1;
    bus.s_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (count !== 11'd5 || bus.bram_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_hold count %0d we %b exp 5 0", count, bus.bram_we);
    end
    checks++;
    if (obs_q.size() != 5) begin
      errors++;
      $display("FAIL abort_write_count got %0d exp 5", obs_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL abort_write[%0d] got %h:%h exp %h:%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_mem[BASE + i] !== exp_mem[BASE + i]) begin
        errors++;
        $display("FAIL abort_readback[%0d] got %h exp %h", i, obs_mem[BASE + i], exp_mem[BASE + i]);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_burst(7, 1'b0, 8'h70, -1);
    rst         = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h77;
    tick();
    @(negedge clock);
    checks++;
    if (bus.bram_we !== 1'b0 || count !== 11'd0 || busy !== 1'b0 || done !== 1'b0 ||
        bus.bram_addr !== 10'(BASE)) begin
      errors++;
      $display("FAIL reset_mid we %b count %0d busy %b done %b addr %h exp 0 0 0 0 %h",
               bus.bram_we, count, busy, done, bus.bram_addr, 10'(BASE));
    end
    checks++;
    if (obs_q.size() != 7) begin
      errors++;
      $display("FAIL reset_mid_writes got %0d exp 7", obs_q.size());
    end
    @(posedge clock);
    #1;
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    tick();
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_burst(N, 1'b0, 8'h90, -1);
    finish_burst("after_reset", 1'b1);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      exp_mem[i] = 8'hxx;
      obs_mem[i] = 8'hxx;
    end
    test_reset();
    test_full_burst();
    test_restart();
    test_gaps();
    test_start_in_load();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
